// File: rtl/prio_sel_driver.sv
// rtl/prio_sel_driver.sv - initiator that drives priority-mux control codes and returns the sampled z bit
// Optional source sweep is compiled in with `define PRIO_SEL_SCAN_EN.
module prio_sel_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_idx,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_bit,
  output logic       rsp_err,
  output logic [2:0] rsp_idx,
  output logic [4:0] sel_c,
  output logic       sel_late,
  input  logic       z_in
`ifdef PRIO_SEL_SCAN_EN
  ,
  input  logic       scan_start,
  output logic [5:0] scan_word,
  output logic       scan_done
`endif
);
  localparam int               SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_EFF - 1);
  localparam logic [4:0]       IDLE_C     = 5'b00000;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             settle_done;
  logic             req_legal;

  function automatic logic [4:0] encode(input logic [2:0] idx);
    case (idx)
      3'd0:    encode = 5'b00001;
      3'd2:    encode = 5'b00110;
      3'd3:    encode = 5'b01010;
      3'd4:    encode = 5'b00010;
      3'd5:    encode = 5'b10010;
      default: encode = 5'b00000;
    endcase
  endfunction

  // Counter value before the exit edge is SETTLE_EFF-1, so sampling lands on accept+SETTLE_EFF.
  assign settle_done = (state == SETTLE) && (cnt == CNT_LAST);
  assign req_legal   = (req_idx <= 3'd5);

`ifdef PRIO_SEL_SCAN_EN
  logic       scan_active;
  logic [2:0] scan_idx;
  logic       scan_last;
  assign scan_last = (scan_idx == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_active <= 1'b0;
      scan_idx    <= 3'd0;
      scan_word   <= 6'b0;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (state == IDLE && scan_start) begin
        scan_active <= 1'b1;
        scan_idx    <= 3'd0;
      end else if (settle_done && scan_active) begin
        scan_word[scan_idx] <= z_in;
        if (scan_last) begin
          scan_active <= 1'b0;
          scan_done   <= 1'b1;
        end else begin
          scan_idx <= scan_idx + 3'd1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
`ifdef PRIO_SEL_SCAN_EN
        if (scan_start) state_nx = SETTLE; else
`endif
        if (req_valid) state_nx = req_legal ? SETTLE : RESP;
      end
      SETTLE: begin
        if (settle_done) begin
`ifdef PRIO_SEL_SCAN_EN
          if (scan_active) state_nx = scan_last ? IDLE : SETTLE; else
`endif
          state_nx = RESP;
        end
      end
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
`ifdef PRIO_SEL_SCAN_EN
    req_ready = (state == IDLE) && !scan_start;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_c     <= IDLE_C;
      sel_late  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_bit   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_idx   <= 3'd0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
`ifdef PRIO_SEL_SCAN_EN
          if (scan_start) begin
            sel_c    <= encode(3'd0);
            sel_late <= 1'b0;
            cnt      <= '0;
          end else
`endif
          if (req_valid) begin
            rsp_idx <= req_idx;
            cnt     <= '0;
            if (req_legal) begin
              sel_c    <= encode(req_idx);
              sel_late <= 1'b0;
            end else begin
              rsp_err   <= 1'b1;
              rsp_bit   <= 1'b0;
              rsp_valid <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_done) begin
            cnt <= '0;
`ifdef PRIO_SEL_SCAN_EN
            if (scan_active) begin
              if (scan_last) begin
                sel_c    <= IDLE_C;
                sel_late <= 1'b1;
              end else begin
                sel_c <= encode(scan_idx + 3'd1);
              end
            end else
`endif
            begin
              rsp_bit   <= z_in;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            sel_c     <= IDLE_C;
            sel_late  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/prio_sel_driver.md
Name: prio_sel_driver

Overview:
- Initiator side of the priority-select mux interface; the mux consumes a 5-bit priority control word, a late-control flag and an 8-bit data vector, and returns a single bit Z.
- Accepts requests carrying a source index and encodes each into the canonical control word plus late flag.
- Holds the code stable for a settle window, captures the returned Z bit and returns it on a response handshake.
- Sits between a test/config controller and the combinational priority mux.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a code and sampling z_in; a value of 0 behaves as 1.
- CNT_W, 4, settle counter width; SETTLE_CYCLES must be below 2**CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  high only in IDLE.
- req_idx  input  3  source index; 0..5 legal, 6..7 illegal.
- rsp_valid  output  1  response valid; held until accepted.
- rsp_ready  input  1  response accept.
- rsp_bit  output  1  captured z_in.
- rsp_err  output  1  illegal index flag.
- rsp_idx  output  3  echo of the accepted req_idx.
- sel_c  output  5  control word to the mux.
- sel_late  output  1  late-control flag to the mux.
- z_in  input  1  mux result.

Behaviour:
- Reset values (async on rst_n low): state IDLE, sel_c=5'b00000, sel_late=1, rsp_valid=0, rsp_bit=0, rsp_err=0, rsp_idx=0, counter=0.
- Encoding, registered on the accepting edge:
  - idx0 -> 00001
  - idx1 -> 00000
  - idx2 -> 00110
  - idx3 -> 01010
  - idx4 -> 00010
  - idx5 -> 10010
  - sel_late=0 for every legal index.
  - Don't-care bits are driven 0.
- Idle code: sel_c=00000, sel_late=1. The downstream mux then selects source 1, which is harmless.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge T with legal idx: drive the code from T, load counter=0, go to SETTLE.
  - On req_valid at edge T with illegal idx: sel_c and sel_late stay idle; rsp_err=1, rsp_bit=0, rsp_valid=1 from T; go to RESP.
  - rsp_idx is captured in both cases.
- SETTLE:
  - Counter increments each edge.
  - At edge T+max(SETTLE_CYCLES,1): sample z_in into rsp_bit, set rsp_err=0 and rsp_valid=1, go to RESP.
  - sel_c and sel_late stay constant throughout SETTLE.
- RESP:
  - sel_c and sel_late stay held.
  - rsp_* outputs are stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid=0, sel_c and sel_late return to the idle code at that same edge, go to IDLE.
  - The next request can be accepted one cycle later.
- Back-to-back: req_ready is 0 outside IDLE. req_valid held through SETTLE and RESP is accepted only after returning to IDLE.
- Reset mid-operation: any state returns to IDLE and idle values immediately; an in-flight response is lost.
- Counter never wraps: SETTLE exits on an equality compare.

Optional Feature:
- Macro: PRIO_SEL_SCAN_EN.
- With the macro, these ports are added:
  - scan_start (input, 1)
  - scan_word (output, 6)
  - scan_done (output, 1)
- scan_start pulse in IDLE (priority over req_valid):
  - Sweeps idx 0..5 in order, each through SETTLE.
  - Stores z_in into scan_word[idx].
  - After idx5, pulses scan_done for 1 cycle and returns to IDLE.
- During the sweep:
  - req_ready=0.
  - No rsp_valid is generated.
  - scan_word holds its value until the next scan.
  - scan_word resets to 0.
- Without the macro: no scan ports, no scan logic, behaviour exactly as above.

Test Plan:
- Reset, then release -> sel_c=00000, sel_late=1, req_ready=1, rsp_valid=0.
- req_idx=3, z_in tied 1, SETTLE_CYCLES=2 -> sel_c=01010 and sel_late=0 from the accept edge; rsp_valid at accept+2 with rsp_bit=1, rsp_err=0, rsp_idx=3.
- req_idx=6 -> rsp_valid next edge with rsp_err=1, sel_c unchanged at 00000.
- rsp_ready held low for 5 cycles with z_in toggling -> rsp_bit, sel_c and rsp_valid stable; after accept, sel_c returns to 00000.
- rst_n low during SETTLE for idx5 -> sel_c returns to 00000 asynchronously; no response appears afterwards.
- With PRIO_SEL_SCAN_EN, a model mux with A=8'b0010_1101, scan_start pulse -> scan_done after 6 sweeps with scan_word=6'b101101.
